// File: rtl/ternary_pkg.sv
// Shared ternary types plus 2-bit saturating branch counter states.
// Trit encoding: 00 = zero, 01 = +1, 10 = -1 (11 unused).
package ternary_pkg;

  typedef logic [1:0] trit_t;
  localparam trit_t T_ZERO    = 2'b00;
  localparam trit_t T_POS_ONE = 2'b01;
  localparam trit_t T_NEG_ONE = 2'b10;

  typedef logic [1:0] bp_ctr_t;
  localparam bp_ctr_t BP_SN = 2'd0;
  localparam bp_ctr_t BP_WN = 2'd1;
  localparam bp_ctr_t BP_WT = 2'd2;
  localparam bp_ctr_t BP_ST = 2'd3;

  // Saturating step; never wraps between SN and ST.
  function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t c, input logic taken);
    if (taken) return (c == BP_ST) ? BP_ST : c + 2'd1;
    else       return (c == BP_SN) ? BP_SN : c - 2'd1;
  endfunction

endpackage

// File: rtl/ternary_offset_sign.sv
// Sign of a balanced-ternary offset: set when the most significant non-zero trit is -1.
// Latency: combinational. Backpressure: none.
// All-zero offset reports non-negative.
module ternary_offset_sign
  import ternary_pkg::*;
#(
  parameter int OFF_TRITS = 2
) (
  input  trit_t [OFF_TRITS-1:0] offset,
  output logic                  is_negative
);

  // Ascending scan: the highest non-zero trit is the last one to write.
  always_comb begin
    is_negative = 1'b0;
    for (int i = 0; i < OFF_TRITS; i++) begin
      if (offset[i] != T_ZERO) is_negative = (offset[i] == T_NEG_ONE);
    end
  end

endmodule

// File: rtl/ternary_bht_predictor.sv
// Direct-mapped BHT of 2-bit counters with static backward-taken fallback for untrained entries.
// Latency: lookup combinational, update visible next cycle. Backpressure: none, one update per cycle.
// Optional TERNARY_BP_STATS_EN adds saturating update/mispredict/static-lookup counters.
module ternary_bht_predictor
  import ternary_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_LSB   = 0,
  parameter int OFF_TRITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_branch,
  input  logic [PC_W-1:0]       pred_pc,
  input  trit_t [OFF_TRITS-1:0] branch_offset,
  output logic                  predict_taken,
  output logic                  pred_dynamic,
  input  logic                  upd_valid,
  input  logic [PC_W-1:0]       upd_pc,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict
`ifdef TERNARY_BP_STATS_EN
  ,
  output logic [31:0]           stat_updates,
  output logic [31:0]           stat_mispredicts,
  output logic [31:0]           stat_static_lookups
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [BHT_DEPTH-1:0] valid;
  bp_ctr_t              ctr [BHT_DEPTH];
  logic [IDX_W-1:0]     lk_idx;
  logic [IDX_W-1:0]     up_idx;
  logic                 offset_negative;

  assign lk_idx = pred_pc[IDX_LSB +: IDX_W];
  assign up_idx = upd_pc[IDX_LSB +: IDX_W];

  ternary_offset_sign #(
    .OFF_TRITS(OFF_TRITS)
  ) u_offset_sign (
    .offset     (branch_offset),
    .is_negative(offset_negative)
  );

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  always_comb begin
    predict_taken = 1'b0;
    pred_dynamic  = 1'b0;
    if (is_branch) begin
      if (valid[lk_idx]) begin
        predict_taken = ctr[lk_idx][1];
        pred_dynamic  = 1'b1;
      end else begin
        predict_taken = offset_negative;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) ctr[i] <= BP_WN;
    end else if (upd_valid) begin
      valid[up_idx] <= 1'b1;
      if (!valid[up_idx]) ctr[up_idx] <= upd_taken ? BP_WT : BP_WN;
      else                ctr[up_idx] <= bp_ctr_next(ctr[up_idx], upd_taken);
    end
  end

`ifdef TERNARY_BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_updates        <= '0;
      stat_mispredicts    <= '0;
      stat_static_lookups <= '0;
    end else begin
      if (upd_valid && stat_updates != '1)
        stat_updates <= stat_updates + 32'd1;
      if (upd_valid && upd_mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 32'd1;
      if (is_branch && !pred_dynamic && stat_static_lookups != '1)
        stat_static_lookups <= stat_static_lookups + 32'd1;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, upd_pc};
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, upd_pc, upd_mispredict};
`endif

endmodule
